// File: rtl/spi_share_ctrl_pkg.sv
// Shared types and helpers for the SPI sharing controller: FSM state encoding,
// default word width and a constant-function log2 used to size the pointer and counter.
package spi_pkg;

    localparam int unsigned DEFAULT_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLo,
        StWaitHi,
        StDone
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_share_ctrl_if.sv
// Bundle of the client request/response lines and the simple_spi engine lines.
// The controller uses the slave view; clients plus the engine form the master view.
interface spi_share_ctrl_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 16
);
    logic [NREQ-1:0]       req;
    logic [NREQ*W-1:0]     req_data;
    logic [NREQ*(W+1)-1:0] req_size;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [W-1:0]          rsp_data;
    logic                  rsp_err;
    logic                  busy;
    logic                  spi_t_begin;
    logic [W-1:0]          spi_data_in;
    logic [W:0]            spi_t_size;
    logic                  spi_cs;
    logic [W-1:0]          spi_data_out;

    modport slave (
        input  req, req_data, req_size, spi_cs, spi_data_out,
        output gnt, rsp_valid, rsp_data, rsp_err, busy, spi_t_begin, spi_data_in, spi_t_size
    );

    modport master (
        output req, req_data, req_size, spi_cs, spi_data_out,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy, spi_t_begin, spi_data_in, spi_t_size
    );

endinterface

// File: rtl/spi_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from ptr upward,
// wrapping at NREQ. Returns one-hot and index of the winner plus an any-request flag.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [PW-1:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = PW'((32'(ptr) + k) % NREQ);
            if (!any && req[pos]) begin
                any         = 1'b1;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/spi_share_ctrl.sv
// Round-robin controller sharing one simple_spi engine between NREQ clients:
// grants a requester, launches the engine, tracks its cs and returns the received word.
module spi_share_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned W         = DEFAULT_W,
    parameter int unsigned START_CYC = 2,
    parameter int unsigned TMO       = 1023
) (
    input logic             sys_clk,
    input logic             rst,
    spi_share_ctrl_if.slave bus
);

    localparam int unsigned PW   = (clog2(NREQ) > 0) ? clog2(NREQ) : 1;
    localparam int unsigned CMAX = (TMO > START_CYC) ? TMO : START_CYC;
    localparam int unsigned CW   = clog2(CMAX + 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] win_q, win_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            t_begin_q, t_begin_d;
    logic [W-1:0]    data_in_q, data_in_d;
    logic [W:0]      t_size_q, t_size_d;

    logic [NREQ-1:0] pick_onehot;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [W-1:0]    sel_data;
    logic [W:0]      sel_size;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_data = '0;
        sel_size = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) begin
                sel_data = bus.req_data[i*W +: W];
                sel_size = bus.req_size[i*(W+1) +: W+1];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        t_begin_d   = t_begin_q;
        data_in_d   = data_in_q;
        t_size_d    = t_size_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    gnt_d     = pick_onehot;
                    win_d     = pick_onehot;
                    ptr_d     = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
                    data_in_d = sel_data;
                    t_size_d  = (sel_size > (W+1)'(W)) ? (W+1)'(W) : sel_size;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    // A zero-length request never touches the engine.
                    if (sel_size == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StStart;
                        t_begin_d = 1'b1;
                    end
                end
            end
            StStart: begin
                if (cnt_q == CW'(START_CYC - 1)) begin
                    state_d   = StWaitLo;
                    t_begin_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitLo: begin
                if (!bus.spi_cs) begin
                    state_d = StWaitHi;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TMO)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitHi: begin
                if (bus.spi_cs) begin
                    state_d = StDone;
                end else if (cnt_q == CW'(TMO)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                rsp_valid_d = win_q;
                rsp_err_d   = err_q;
                if (t_size_q != '0) begin
                    rsp_data_d = bus.spi_data_out;
                end
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            t_begin_q   <= 1'b0;
            data_in_q   <= '0;
            t_size_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            t_begin_q   <= t_begin_d;
            data_in_q   <= data_in_d;
            t_size_q    <= t_size_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.spi_t_begin = t_begin_q;
    assign bus.spi_data_in = data_in_q;
    assign bus.spi_t_size  = t_size_q;

endmodule

// File: tb/tb_spi_share_ctrl.sv
// Bench for spi_share_ctrl with a behavioural stand-in for simple_spi (miso looped to mosi):
// cs drops the cycle after t_begin is seen and stays low 2*size+2 cycles.
module tb_spi_share_ctrl;

    localparam int NREQ      = 4;
    localparam int W         = 16;
    localparam int START_CYC = 2;
    localparam int TMO       = 1023;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    spi_share_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

    spi_share_ctrl #(
        .NREQ      (NREQ),
        .W         (W),
        .START_CYC (START_CYC),
        .TMO       (TMO)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Engine stand-in; stub_hi pins cs high to force a timeout.
    bit           stub_hi = 1'b0;
    logic [W-1:0] stub_word = '0;
    logic         eng_busy;
    int           eng_cnt;
    logic [W-1:0] eng_word;

    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            bus.spi_cs       <= 1'b1;
            bus.spi_data_out <= '0;
            eng_busy         <= 1'b0;
            eng_cnt          <= 0;
            eng_word         <= '0;
        end else if (stub_hi) begin
            bus.spi_cs       <= 1'b1;
            bus.spi_data_out <= stub_word;
        end else if (!eng_busy) begin
            if (bus.spi_t_begin) begin
                eng_busy   <= 1'b1;
                bus.spi_cs <= 1'b0;
                eng_cnt    <= 2 * int'(bus.spi_t_size) + 2;
                eng_word   <= (bus.spi_t_size >= (W+1)'(W)) ? bus.spi_data_in :
                              bus.spi_data_in & ((W'(1) << bus.spi_t_size) - W'(1));
            end
        end else if (eng_cnt <= 1) begin
            bus.spi_cs       <= 1'b1;
            eng_busy         <= 1'b0;
            bus.spi_data_out <= eng_word;
        end else begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    // Reference model state
    int           model_ptr = 0;
    logic [W-1:0] last_rsp  = '0;

    function automatic int model_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int clamp(input int s);
        return (s > W) ? W : s;
    endfunction

    function automatic logic [W-1:0] exp_word(input logic [W-1:0] d, input int s);
        logic [W-1:0] m;
        m = '1;
        if (clamp(s) < W) m = m >> (W - clamp(s));
        return d & m;
    endfunction

    // Engine timing: t_begin seen one edge after gnt, cs low 2s+2 cycles, then DONE and rsp.
    function automatic int exp_lat(input int s);
        return (s == 0) ? 1 : 2 * clamp(s) + 5;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_slot(input int i, input logic [W-1:0] d, input int s);
        bus.req_data[i*W +: W]         = d;
        bus.req_size[i*(W+1) +: (W+1)] = (W+1)'(s);
    endtask

    task automatic wait_gnt(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.gnt != '0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int start, output int cyc, output int tb_hi);
        cyc   = -1;
        tb_hi = 0;
        for (int i = start + 1; i <= start + 1200; i++) begin
            tick();
            if (bus.spi_t_begin) tb_hi++;
            if (bus.rsp_valid != '0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst       = 1'b0;
        model_ptr = 0;
        last_rsp  = '0;
    endtask

    task automatic test_reset();
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_size = '0;
        tick();
        tick();
        n_cmp++;
        if ({bus.gnt, bus.rsp_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_gnt_valid: got %b/%b want 0/0", bus.gnt, bus.rsp_valid);
        end
        n_cmp++;
        if ({bus.rsp_data, bus.rsp_err, bus.busy, bus.spi_t_begin} !== '0) begin
            n_err++;
            $display("FAIL reset_rsp_busy: got data %h err %b busy %b tb %b want all 0",
                     bus.rsp_data, bus.rsp_err, bus.busy, bus.spi_t_begin);
        end
        n_cmp++;
        if ({bus.spi_data_in, bus.spi_t_size} !== '0) begin
            n_err++;
            $display("FAIL reset_spi: got data_in %h t_size %0d want 0", bus.spi_data_in,
                     bus.spi_t_size);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int cyc;
        int hi;
        drive_slot(0, 16'h00EE, 16);
        bus.req = 4'b0001;
        wait_gnt(cyc);
        bus.req = '0;
        n_cmp++;
        if (cyc != 1 || bus.gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL single_gnt: got gnt %b after %0d want 0001 after 1", bus.gnt, cyc);
        end
        n_cmp++;
        if (bus.spi_data_in !== 16'h00EE || bus.spi_t_size !== 17'd16) begin
            n_err++;
            $display("FAIL single_latch: got %h/%0d want 00ee/16", bus.spi_data_in,
                     bus.spi_t_size);
        end
        n_cmp++;
        if (bus.spi_t_begin !== 1'b1 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_start: got t_begin %b busy %b want 1 1", bus.spi_t_begin,
                     bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.spi_t_begin !== 1'b1 || bus.gnt !== '0) begin
            n_err++;
            $display("FAIL single_start2: got t_begin %b gnt %b want 1 0000", bus.spi_t_begin,
                     bus.gnt);
        end
        tick();
        n_cmp++;
        if (bus.spi_t_begin !== 1'b0) begin
            n_err++;
            $display("FAIL single_start_len: got t_begin %b want 0", bus.spi_t_begin);
        end
        wait_rsp(2, cyc, hi);
        model_ptr = 1;
        last_rsp  = 16'h00EE;
        n_cmp++;
        if (cyc != exp_lat(16) || bus.rsp_valid !== 4'b0001) begin
            n_err++;
            $display("FAIL single_rsp: got valid %b after %0d want 0001 after %0d",
                     bus.rsp_valid, cyc, exp_lat(16));
        end
        n_cmp++;
        if (bus.rsp_data !== 16'h00EE || bus.rsp_err !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_data: got %h err %b busy %b want 00ee 0 0", bus.rsp_data,
                     bus.rsp_err, bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.rsp_valid !== '0) begin
            n_err++;
            $display("FAIL single_pulse: got %b want 0000", bus.rsp_valid);
        end
    endtask

    task automatic test_rotation();
        logic [W-1:0] words [NREQ];
        int cyc;
        int hi;
        int exp;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            words[i] = {4'(i + 1), 12'($urandom)};
            drive_slot(i, words[i], W);
        end
        bus.req = '1;
        for (int k = 0; k <= NREQ; k++) begin
            exp = model_pick(bus.req);
            wait_gnt(cyc);
            n_cmp++;
            if (cyc != 1 || bus.gnt !== NREQ'(1 << exp)) begin
                n_err++;
                $display("FAIL rotation_gnt%0d: got %b after %0d want %b after 1", k, bus.gnt,
                         cyc, NREQ'(1 << exp));
            end
            model_ptr = (exp + 1) % NREQ;
            wait_rsp(0, cyc, hi);
            n_cmp++;
            if (bus.rsp_valid !== NREQ'(1 << exp) || bus.rsp_data !== words[exp]) begin
                n_err++;
                $display("FAIL rotation_rsp%0d: got %b/%h want %b/%h", k, bus.rsp_valid,
                         bus.rsp_data, NREQ'(1 << exp), words[exp]);
            end
            last_rsp = words[exp];
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_size_zero();
        int cyc;
        int hi;
        drive_slot(2, W'($urandom), 0);
        bus.req = 4'b0100;
        wait_gnt(cyc);
        bus.req = '0;
        n_cmp++;
        if (bus.gnt !== 4'b0100 || bus.spi_t_begin !== 1'b0) begin
            n_err++;
            $display("FAIL zero_gnt: got gnt %b t_begin %b want 0100 0", bus.gnt,
                     bus.spi_t_begin);
        end
        model_ptr = 3;
        wait_rsp(0, cyc, hi);
        n_cmp++;
        if (cyc != 1 || bus.rsp_valid !== 4'b0100 || hi != 0) begin
            n_err++;
            $display("FAIL zero_rsp: got valid %b after %0d t_begin hi %0d want 0100 after 1 0",
                     bus.rsp_valid, cyc, hi);
        end
        n_cmp++;
        if (bus.rsp_data !== last_rsp || bus.rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL zero_data: got %h err %b want %h 0", bus.rsp_data, bus.rsp_err,
                     last_rsp);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int hi;
        int exp;
        stub_word = W'($urandom);
        stub_hi   = 1'b1;
        tick();
        drive_slot(1, W'($urandom), 8);
        bus.req = 4'b0010;
        exp = model_pick(bus.req);
        wait_gnt(cyc);
        bus.req   = '0;
        model_ptr = (exp + 1) % NREQ;
        wait_rsp(0, cyc, hi);
        n_cmp++;
        if (cyc != TMO + START_CYC + 2 || bus.rsp_valid !== 4'b0010) begin
            n_err++;
            $display("FAIL timeout_lat: got valid %b after %0d want 0010 after %0d",
                     bus.rsp_valid, cyc, TMO + START_CYC + 2);
        end
        n_cmp++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_data !== stub_word) begin
            n_err++;
            $display("FAIL timeout_err: got err %b data %h want 1 %h", bus.rsp_err,
                     bus.rsp_data, stub_word);
        end
        last_rsp = stub_word;
        stub_hi  = 1'b0;
        tick();
        n_cmp++;
        if (bus.rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_err_pulse: got %b want 0", bus.rsp_err);
        end
    endtask

    task automatic test_rst_mid();
        int cyc;
        int hi;
        int s;
        logic [W-1:0] d;
        drive_slot(0, W'($urandom), 16);
        bus.req = 4'b0001;
        wait_gnt(cyc);
        bus.req = '0;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.spi_cs !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_pre: got busy %b cs %b want 1 0", bus.busy, bus.spi_cs);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy, bus.spi_t_begin,
             bus.spi_data_in, bus.spi_t_size} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_zero: got busy %b t_begin %b data_in %h t_size %0d want 0",
                     bus.busy, bus.spi_t_begin, bus.spi_data_in, bus.spi_t_size);
        end
        tick();
        rst       = 1'b0;
        model_ptr = 0;
        last_rsp  = '0;
        d = W'($urandom);
        s = $urandom_range(1, W);
        drive_slot(1, d, s);
        bus.req = 4'b0010;
        wait_gnt(cyc);
        bus.req   = '0;
        model_ptr = 2;
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL rst_mid_gnt: got %b want 0010", bus.gnt);
        end
        wait_rsp(0, cyc, hi);
        n_cmp++;
        if (bus.rsp_valid !== 4'b0010 || cyc != exp_lat(s) || bus.rsp_data !== exp_word(d, s)) begin
            n_err++;
            $display("FAIL rst_mid_rsp: got %b after %0d data %h want 0010 after %0d data %h",
                     bus.rsp_valid, cyc, bus.rsp_data, exp_lat(s), exp_word(d, s));
        end
        last_rsp = exp_word(d, s);
    endtask

    task automatic test_withdraw();
        int cyc;
        int hi;
        int s;
        int extra;
        logic [W-1:0] d;
        d = W'($urandom);
        s = $urandom_range(1, W);
        drive_slot(3, d, s);
        bus.req = 4'b1000;
        wait_gnt(cyc);
        model_ptr = 0;
        tick();
        bus.req = '0;
        wait_rsp(1, cyc, hi);
        n_cmp++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== exp_word(d, s) || bus.rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL withdraw_rsp: got %b data %h err %b want 1000 data %h err 0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_err, exp_word(d, s));
        end
        last_rsp = exp_word(d, s);
        extra    = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid != '0 || bus.gnt != '0) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL withdraw_once: got %0d extra pulses want 0", extra);
        end
    endtask

    task automatic test_random();
        logic [W-1:0]    d [NREQ];
        int              s [NREQ];
        logic [NREQ-1:0] mask;
        int cyc;
        int hi;
        int exp;
        logic [W-1:0] want;
        for (int it = 0; it < 30; it++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                d[i] = W'($urandom);
                case ($urandom_range(0, 7))
                    0:       s[i] = 0;
                    1:       s[i] = $urandom_range(W + 1, 2 * W);
                    default: s[i] = $urandom_range(1, W);
                endcase
                drive_slot(i, d[i], s[i]);
            end
            bus.req = mask;
            exp = model_pick(mask);
            wait_gnt(cyc);
            bus.req = '0;
            n_cmp++;
            if (bus.gnt !== NREQ'(1 << exp) || bus.spi_data_in !== d[exp] ||
                bus.spi_t_size !== (W+1)'(clamp(s[exp]))) begin
                n_err++;
                $display("FAIL random_gnt%0d: got %b %h/%0d want %b %h/%0d", it, bus.gnt,
                         bus.spi_data_in, bus.spi_t_size, NREQ'(1 << exp), d[exp],
                         clamp(s[exp]));
            end
            model_ptr = (exp + 1) % NREQ;
            want = (s[exp] == 0) ? last_rsp : exp_word(d[exp], s[exp]);
            wait_rsp(0, cyc, hi);
            n_cmp++;
            if (bus.rsp_valid !== NREQ'(1 << exp) || cyc != exp_lat(s[exp]) ||
                bus.rsp_data !== want || bus.rsp_err !== 1'b0) begin
                n_err++;
                $display("FAIL random_rsp%0d: got %b after %0d data %h err %b want %b after %0d data %h",
                         it, bus.rsp_valid, cyc, bus.rsp_data, bus.rsp_err, NREQ'(1 << exp),
                         exp_lat(s[exp]), want);
            end
            last_rsp = want;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_size_zero();
        test_timeout();
        test_rst_mid();
        test_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
